// File: rtl/can_frame_rx.sv
// CAN base-format frame receiver: deserialises SOF..data, checks the fixed-zero
// control bits, runs CRC-15 and presents the frame as a one-cycle valid pulse.
module can_frame_rx (
    input  logic        clk,
    input  logic        rst,
    input  logic        bit_in,
    output logic [10:0] RX_ID,
    output logic [3:0]  RX_DLC,
    output logic [7:0]  RX_DATA [7:0],
    output logic        RX_VALID,
    output logic        RX_BUSY,
    output logic        RX_ERR,
    output logic [14:0] RX_CRC,
    output logic [6:0]  rx_index
);

    typedef enum logic [1:0] {IDLE, READY, RECV, DONE} state_t;

    state_t      state, state_nx;
    logic [10:0] id_sh, id_nx;
    logic [3:0]  dlc_sh, dlc_nx;
    logic [7:0]  data_sh [7:0];
    logic [7:0]  data_nx [7:0];
    logic [14:0] crc_sh, crc_nx;
    logic [3:0]  nbytes;
    logic [6:0]  last_idx;
    logic [5:0]  off;
    logic        form_err;
    logic        is_last;

    function automatic logic [14:0] crc_step(input logic [14:0] crc, input logic b);
        logic nxt;
        nxt = b ^ crc[14];
        crc_step = {crc[13:0], 1'b0} ^ (nxt ? 15'h4599 : 15'h0000);
    endfunction

    // Shadow-register next values with the bit currently on the wire folded in,
    // so the final sample can be published in the same edge.
    always_comb begin
        id_nx    = id_sh;
        dlc_nx   = dlc_sh;
        data_nx  = data_sh;
        crc_nx   = crc_step(crc_sh, bit_in);
        off      = rx_index[5:0] - 6'd19;
        if (rx_index >= 7'd1 && rx_index <= 7'd11)
            id_nx = {id_sh[9:0], bit_in};
        if (rx_index >= 7'd15 && rx_index <= 7'd18)
            dlc_nx = {dlc_sh[2:0], bit_in};
        if (rx_index >= 7'd19)
            data_nx[off[5:3]][3'd7 - off[2:0]] = bit_in;
        nbytes   = dlc_nx[3] ? 4'd8 : dlc_nx;
        last_idx = 7'd18 + {nbytes, 3'b000};
        form_err = (state == RECV) && bit_in && (rx_index >= 7'd12) && (rx_index <= 7'd14);
        is_last  = (state == RECV) && (rx_index >= 7'd18) && (rx_index == last_idx);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bit_in) state_nx = READY;
            READY:   if (!bit_in) state_nx = RECV;
            RECV: begin
                if (form_err)     state_nx = IDLE;
                else if (is_last) state_nx = DONE;
            end
            default: state_nx = READY;
        endcase
    end

    assign RX_VALID = (state == DONE);
    assign RX_BUSY  = (state == RECV);

    always_ff @(posedge clk) begin
        if (rst) begin
            RX_ID    <= '0;
            RX_DLC   <= '0;
            RX_CRC   <= '0;
            RX_ERR   <= 1'b0;
            rx_index <= '0;
            id_sh    <= '0;
            dlc_sh   <= '0;
            crc_sh   <= '0;
            for (int i = 0; i < 8; i++) begin
                RX_DATA[i] <= '0;
                data_sh[i] <= '0;
            end
        end else begin
            RX_ERR <= form_err;
            case (state)
                READY: begin
                    if (!bit_in) begin
                        rx_index <= 7'd1;
                        crc_sh   <= crc_step(15'h0000, bit_in);
                        id_sh    <= '0;
                        dlc_sh   <= '0;
                        for (int i = 0; i < 8; i++) data_sh[i] <= '0;
                    end
                end
                RECV: begin
                    if (form_err) begin
                        rx_index <= '0;
                    end else begin
                        id_sh  <= id_nx;
                        dlc_sh <= dlc_nx;
                        crc_sh <= crc_nx;
                        for (int i = 0; i < 8; i++) data_sh[i] <= data_nx[i];
                        if (is_last) begin
                            rx_index <= '0;
                            RX_ID    <= id_nx;
                            RX_DLC   <= dlc_nx;
                            RX_CRC   <= crc_nx;
                            for (int i = 0; i < 8; i++) RX_DATA[i] <= data_nx[i];
                        end else begin
                            rx_index <= rx_index + 7'd1;
                        end
                    end
                end
                default: rx_index <= '0;
            endcase
        end
    end

endmodule
